// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control sequencer.
// Default mult/div latencies and the stall counter width.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF = 32;
    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks HI/LO occupancy after a mult/div starts in EX.
// Busy stays high for exactly the selected latency; a new start reloads the counter.
module md_busy_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_i,
    input  logic md_is_div_i,
    output logic md_busy_o
);

    md_state_t          r_state;
    md_state_t          w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (md_start_i) begin
            w_state_next = MD_BUSY;
            w_cnt_next   = md_is_div_i ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (r_state == MD_BUSY) begin
            // Count value 1 marks the final busy cycle.
            if (r_cnt == CNT_W'(1)) begin
                w_state_next = MD_IDLE;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next = r_cnt - CNT_W'(1);
            end
        end
    end

    assign md_busy_o = (r_state == MD_BUSY);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control sequencer: turns load-use, branch, HI/LO and memory-wait
// hazards into stall/flush controls for the fetch, issue and EX stages.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             rs_iss_i,
    input  logic [4:0]             rt_iss_i,
    input  logic                   use_rs_iss_i,
    input  logic                   use_rt_iss_i,
    input  logic [4:0]             rt_ex_i,
    input  logic                   mem_to_reg_ex_i,
    input  logic                   branch_taken_ex_i,
    input  logic                   md_start_ex_i,
    input  logic                   md_is_div_ex_i,
    input  logic                   md_use_iss_i,
    input  logic                   dmem_wait_i,
    output logic                   stall_fetch_o,
    output logic                   stall_iss_o,
    output logic                   stall_ex_o,
    output logic                   flush_iss_o,
    output logic                   flush_ex_o,
    output logic                   md_busy_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    logic                   w_md_busy;
    logic                   w_load_use;
    logic                   w_md_hazard;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    md_busy_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_busy_tracker (
        .clk         (clk),
        .reset       (reset),
        .md_start_i  (md_start_ex_i),
        .md_is_div_i (md_is_div_ex_i),
        .md_busy_o   (w_md_busy)
    );

    // A load into $zero never produces a usable value, so it cannot cause a hazard.
    assign w_load_use = mem_to_reg_ex_i && (rt_ex_i != 5'd0) &&
                        ((use_rs_iss_i && (rs_iss_i == rt_ex_i)) ||
                         (use_rt_iss_i && (rt_iss_i == rt_ex_i)));

    assign w_md_hazard = w_md_busy && md_use_iss_i;

    always_comb begin
        stall_fetch_o = 1'b0;
        stall_iss_o   = 1'b0;
        stall_ex_o    = 1'b0;
        flush_iss_o   = 1'b0;
        flush_ex_o    = 1'b0;
        if (reset) begin
            // All controls idle while in reset.
        end else if (dmem_wait_i) begin
            stall_fetch_o = 1'b1;
            stall_iss_o   = 1'b1;
            stall_ex_o    = 1'b1;
        end else if (branch_taken_ex_i) begin
            flush_iss_o = 1'b1;
            flush_ex_o  = 1'b1;
        end else if (w_md_hazard || w_load_use) begin
            stall_fetch_o = 1'b1;
            stall_iss_o   = 1'b1;
            flush_ex_o    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall_iss_o && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign md_busy_o   = w_md_busy && !reset;
    assign stall_cnt_o = reset ? '0 : r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: inputs change 1 ns after the rising edge,
// outputs are checked on the falling edge against hand-derived values.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_iss_i;
    logic [4:0]  rt_iss_i;
    logic        use_rs_iss_i;
    logic        use_rt_iss_i;
    logic [4:0]  rt_ex_i;
    logic        mem_to_reg_ex_i;
    logic        branch_taken_ex_i;
    logic        md_start_ex_i;
    logic        md_is_div_ex_i;
    logic        md_use_iss_i;
    logic        dmem_wait_i;
    logic        stall_fetch_o;
    logic        stall_iss_o;
    logic        stall_ex_o;
    logic        flush_iss_o;
    logic        flush_ex_o;
    logic        md_busy_o;
    logic [15:0] stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(
        .MUL_LAT (4),
        .DIV_LAT (32),
        .CNT_W   (6)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rs_iss_i          (rs_iss_i),
        .rt_iss_i          (rt_iss_i),
        .use_rs_iss_i      (use_rs_iss_i),
        .use_rt_iss_i      (use_rt_iss_i),
        .rt_ex_i           (rt_ex_i),
        .mem_to_reg_ex_i   (mem_to_reg_ex_i),
        .branch_taken_ex_i (branch_taken_ex_i),
        .md_start_ex_i     (md_start_ex_i),
        .md_is_div_ex_i    (md_is_div_ex_i),
        .md_use_iss_i      (md_use_iss_i),
        .dmem_wait_i       (dmem_wait_i),
        .stall_fetch_o     (stall_fetch_o),
        .stall_iss_o       (stall_iss_o),
        .stall_ex_o        (stall_ex_o),
        .flush_iss_o       (flush_iss_o),
        .flush_ex_o        (flush_ex_o),
        .md_busy_o         (md_busy_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Order: stall_fetch, stall_iss, stall_ex, flush_iss, flush_ex.
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {11'd0, stall_fetch_o, stall_iss_o, stall_ex_o, flush_iss_o, flush_ex_o},
              {11'd0, exp});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rs_iss_i          = 5'd0;
        rt_iss_i          = 5'd0;
        use_rs_iss_i      = 1'b0;
        use_rt_iss_i      = 1'b0;
        rt_ex_i           = 5'd0;
        mem_to_reg_ex_i   = 1'b0;
        branch_taken_ex_i = 1'b0;
        md_start_ex_i     = 1'b0;
        md_is_div_ex_i    = 1'b0;
        md_use_iss_i      = 1'b0;
        dmem_wait_i       = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        branch_taken_ex_i = 1'b1;
        dmem_wait_i       = 1'b1;
        next_cycle();
        next_cycle();
        sample();
        check_ctl("reset_ctl", 5'b00000);
        check("reset_busy", {15'd0, md_busy_o}, 16'd0);
        check("reset_cnt", stall_cnt_o, 16'd0);
        next_cycle();

        reset = 1'b0;
        clear_inputs();
        sample();
        check_ctl("idle_ctl", 5'b00000);
        check("idle_cnt", stall_cnt_o, 16'd0);
        next_cycle();

        // Load-use through rs.
        mem_to_reg_ex_i = 1'b1;
        rt_ex_i         = 5'd5;
        rs_iss_i        = 5'd5;
        use_rs_iss_i    = 1'b1;
        sample();
        check_ctl("lu_rs_ctl", 5'b11001);
        check("lu_rs_cnt_before", stall_cnt_o, 16'd0);
        next_cycle();
        clear_inputs();
        sample();
        check_ctl("lu_rs_after", 5'b00000);
        check("lu_rs_cnt_after", stall_cnt_o, 16'd1);
        next_cycle();

        // Load-use through rt, then the same match without use_rt.
        mem_to_reg_ex_i = 1'b1;
        rt_ex_i         = 5'd7;
        rt_iss_i        = 5'd7;
        use_rt_iss_i    = 1'b1;
        sample();
        check_ctl("lu_rt_ctl", 5'b11001);
        next_cycle();
        use_rt_iss_i = 1'b0;
        sample();
        check_ctl("lu_rt_unused", 5'b00000);
        check("lu_rt_cnt", stall_cnt_o, 16'd2);
        next_cycle();

        // Load into $zero never stalls.
        clear_inputs();
        mem_to_reg_ex_i = 1'b1;
        rt_ex_i         = 5'd0;
        rs_iss_i        = 5'd0;
        use_rs_iss_i    = 1'b1;
        sample();
        check_ctl("lu_zero", 5'b00000);
        next_cycle();

        // Branch beats load-use.
        rt_ex_i           = 5'd9;
        rs_iss_i          = 5'd9;
        branch_taken_ex_i = 1'b1;
        sample();
        check_ctl("br_over_lu", 5'b00011);
        next_cycle();
        clear_inputs();
        sample();
        check("br_cnt", stall_cnt_o, 16'd2);
        next_cycle();

        // DIV window from a fresh stall count.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        md_start_ex_i  = 1'b1;
        md_is_div_ex_i = 1'b1;
        sample();
        check("div_start_busy", {15'd0, md_busy_o}, 16'd0);
        check("div_start_cnt", stall_cnt_o, 16'd0);
        next_cycle();
        md_start_ex_i  = 1'b0;
        md_is_div_ex_i = 1'b0;
        md_use_iss_i   = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            sample();
            check($sformatf("div_busy_%0d", i), {15'd0, md_busy_o}, 16'd1);
            check($sformatf("div_ctl_%0d", i), {11'd0, stall_fetch_o, stall_iss_o, stall_ex_o,
                  flush_iss_o, flush_ex_o}, 16'b11001);
            next_cycle();
        end
        sample();
        check("div_release_busy", {15'd0, md_busy_o}, 16'd0);
        check_ctl("div_release_ctl", 5'b00000);
        check("div_cnt", stall_cnt_o, 16'd32);
        next_cycle();

        // MULT restarted two cycles after the first start.
        md_use_iss_i  = 1'b0;
        md_start_ex_i = 1'b1;
        next_cycle();
        md_start_ex_i = 1'b0;
        sample();
        check("mul_busy_1", {15'd0, md_busy_o}, 16'd1);
        next_cycle();
        md_start_ex_i = 1'b1;
        sample();
        check("mul_busy_2", {15'd0, md_busy_o}, 16'd1);
        next_cycle();
        md_start_ex_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sample();
            check($sformatf("mul_reload_busy_%0d", i), {15'd0, md_busy_o}, 16'd1);
            next_cycle();
        end
        sample();
        check("mul_end", {15'd0, md_busy_o}, 16'd0);
        next_cycle();

        // Memory wait holds a taken branch for three cycles.
        branch_taken_ex_i = 1'b1;
        dmem_wait_i       = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sample();
            check_ctl($sformatf("dmem_ctl_%0d", i), 5'b11100);
            next_cycle();
        end
        dmem_wait_i = 1'b0;
        sample();
        check_ctl("dmem_release_br", 5'b00011);
        check("dmem_cnt", stall_cnt_o, 16'd35);
        next_cycle();
        clear_inputs();

        // Reset in the middle of a divide.
        md_start_ex_i  = 1'b1;
        md_is_div_ex_i = 1'b1;
        next_cycle();
        md_start_ex_i  = 1'b0;
        md_is_div_ex_i = 1'b0;
        md_use_iss_i   = 1'b1;
        for (int i = 0; i < 5; i++) next_cycle();
        sample();
        check("mid_div_busy", {15'd0, md_busy_o}, 16'd1);
        check("mid_div_cnt", stall_cnt_o, 16'd40);
        next_cycle();
        reset = 1'b1;
        sample();
        check_ctl("rst_hold_ctl", 5'b00000);
        check("rst_hold_busy", {15'd0, md_busy_o}, 16'd0);
        check("rst_hold_cnt", stall_cnt_o, 16'd0);
        next_cycle();
        reset = 1'b0;
        sample();
        check("post_rst_busy", {15'd0, md_busy_o}, 16'd0);
        check_ctl("post_rst_ctl", 5'b00000);
        check("post_rst_cnt", stall_cnt_o, 16'd0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipeline control sequencer for the five-stage MIPS core (fetch, issue, EX, MEM, WB). It turns raw hazard conditions into per-stage stall, flush and hold controls. The conditions are load-use dependences, taken branches resolved in EX, multi-cycle multiply/divide occupancy of HI/LO, and data-memory wait. It sits beside the forwarding logic and drives the enables and clears of the fetch/issue, issue/EX and EX/MEM pipeline registers.

## Interface
- MUL_LAT, 4, cycles HI/LO stays busy after a MULT/MULTU starts
- DIV_LAT, 32, cycles HI/LO stays busy after a DIV/DIVU starts
- CNT_W, 6, busy counter width; must hold DIV_LAT
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rs_iss_i  in  5  rs of instruction in issue
- rt_iss_i  in  5  rt of instruction in issue
- use_rs_iss_i  in  1  issue instruction reads rs
- use_rt_iss_i  in  1  issue instruction reads rt
- rt_ex_i  in  5  destination of instruction in EX
- mem_to_reg_ex_i  in  1  EX instruction is a load
- branch_taken_ex_i  in  1  branch/jump in EX redirects PC
- md_start_ex_i  in  1  mult/div begins in EX this cycle
- md_is_div_ex_i  in  1  qualifies md_start_ex_i: 1 = divide
- md_use_iss_i  in  1  issue instruction reads HI/LO or is a mult/div
- dmem_wait_i  in  1  data memory not ready; freeze pipeline
- stall_fetch_o  out  1  hold PC and the fetch/issue register
- stall_iss_o  out  1  hold the issue register contents
- stall_ex_o  out  1  hold the EX/MEM register (memory wait only)
- flush_iss_o  out  1  clear the fetch/issue register at next edge
- flush_ex_o  out  1  insert a bubble into the issue/EX register at next edge
- md_busy_o  out  1  HI/LO result pending
- stall_cnt_o  out  16  saturating count of cycles with stall_iss_o high

## Operation
- Priority, highest first: reset, dmem_wait, branch, md hazard, load-use.
- Load-use hazard: mem_to_reg_ex_i & rt_ex_i≠0 & ((use_rs_iss_i & rs_iss_i==rt_ex_i) | (use_rt_iss_i & rt_iss_i==rt_ex_i)).
  - Response: stall_fetch_o=stall_iss_o=flush_ex_o=1 for exactly that cycle.
- Branch: branch_taken_ex_i gives flush_iss_o=flush_ex_o=1.
  - Stalls are 0.
  - Overrides load-use and md hazards in the same cycle, because the issue instruction is wrong-path.
  - No architectural delay slot.
- MD tracker FSM has two states, MD_IDLE and MD_BUSY.
  - md_start_ex_i in either state loads the counter with DIV_LAT or MUL_LAT and enters MD_BUSY. A restart while busy reloads the counter.
  - In MD_BUSY the counter decrements each cycle. It returns to MD_IDLE when the counter reaches 1 and no new start occurs.
  - md_busy_o equals (state==MD_BUSY).
- MD hazard: md_busy_o & md_use_iss_i gives stall_fetch_o=stall_iss_o=flush_ex_o=1.
- dmem_wait_i gives stall_fetch_o=stall_iss_o=stall_ex_o=1, with flush_iss_o=flush_ex_o=0.
  - branch_taken_ex_i and load-use are ignored; they re-present once the wait clears.
  - The MD counter keeps decrementing because the divider runs freely.
- stall_cnt_o increments on every cycle with stall_iss_o=1 and saturates at 16'hFFFF.

## Timing
- All stall and flush outputs are combinational from the inputs and the registered state, with zero-cycle latency.
- md_start_ex_i high in cycle N: md_busy_o is high in cycles N+1 through N+LAT and low in cycle N+LAT+1.
- stall_cnt_o updates one cycle after the stall cycle it counts.
- Reset, sampled high at an edge:
  - state becomes MD_IDLE, the counter 0, and stall_cnt_o 0.
  - While reset is high, every output is forced to 0.
  - Reset mid-divide abandons the busy window immediately.
- rt_ex_i==0 never triggers load-use, including for a load into $zero.

## Structure
- Package pipe_ctrl_pkg holds:
  - the md_state_t enum (MD_IDLE, MD_BUSY)
  - the MUL_LAT_DEF and DIV_LAT_DEF constants
  - the STALL_CNT_W=16 constant
- Sub-module md_busy_tracker contains the FSM and latency counter and outputs md_busy.
- Top level holds the hazard compare, the priority mux and the stall counter.

## Test plan
- Load $5 in EX (rt_ex_i=5) with issue rs=5 and use_rs=1 -> one cycle of stall_fetch=stall_iss=flush_ex=1, then all 0; stall_cnt_o=1.
- Load to $0 with issue rs=0 -> no stall.
- Load-use and branch_taken_ex_i in the same cycle -> flush_iss=flush_ex=1 and stall_iss=0.
- DIV start at cycle 10 with MFLO in issue from cycle 11 -> md_busy and stall_iss high in cycles 11..42, released at 43; stall_cnt_o=32.
- MULT start, second MULT start 2 cycles later -> busy reloads to 4 and ends 4 cycles after the second start.
- dmem_wait_i high for 3 cycles during a taken branch -> stall_ex=1 and flush outputs 0 for 3 cycles, then flush_iss=flush_ex=1 in the cycle dmem_wait_i drops.
- Reset asserted mid-DIV -> next cycle md_busy=0, stall_cnt_o=0 and all outputs 0.
